s2p_frame_ctrl: RTL and testbench
=================================

S2P_FRAME_CTRL -- requirements
Module: s2p_frame_ctrl

Interface
REQ-001 Parameter COM, default 8'hBC, alignment character.
REQ-002 Parameter LOCK_COUNT, default 4, consecutive byte-aligned COM characters required to lock.
REQ-003 Parameter MAX_GAP, default 16, consecutive non-COM bytes in ACTIVE that cause loss of lock.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 din  input  1  serial data, MSB first, one bit sampled per rising clk edge.
REQ-007 data_out  output  8  aligned parallel byte.
REQ-008 valid  output  1  one-cycle strobe qualifying data_out.
REQ-009 active  output  1  high while byte alignment is locked.

Function
REQ-010 The block SHALL hold an 8-bit shift register, sr <= {sr[6:0], din} every cycle; window w = {sr[6:0], din}.
REQ-011 The block SHALL implement a 3-state FSM: SEARCH, ALIGN, ACTIVE.
REQ-012 SEARCH: when w == COM, the block SHALL go to ALIGN with bit_cnt = 0 and com_cnt = 1; otherwise it SHALL stay in SEARCH.
REQ-013 In ALIGN and ACTIVE, bit_cnt SHALL increment modulo 8 each cycle; a byte boundary is the edge where bit_cnt == 7.
REQ-014 ALIGN at a boundary: w == COM and com_cnt+1 == LOCK_COUNT -> ACTIVE; w == COM otherwise -> com_cnt+1, stay; w != COM -> SEARCH, com_cnt = 0.
REQ-015 The COM that completes lock SHALL NOT be output; the first valid byte SHALL be the next full byte.
REQ-016 ACTIVE at each boundary: data_out <= w and valid = 1 for exactly one cycle; COM bytes SHALL also be output.
REQ-017 ACTIVE: gap_cnt SHALL clear on a COM byte and increment on a non-COM byte.
REQ-018 When a non-COM byte brings gap_cnt to MAX_GAP, the block SHALL go to SEARCH, discard that byte (valid = 0) and deassert active on the same edge.
REQ-019 active SHALL be registered and high exactly when the state is ACTIVE.
REQ-020 valid SHALL never be 1 while active is 0.
REQ-021 Between boundaries, data_out SHALL hold its last value; valid SHALL be 0.
REQ-022 Latency: valid and data_out SHALL update on the same edge that samples the 8th bit of the byte; there is no extra pipeline stage.
REQ-023 SEARCH SHALL re-arm from the current window: a COM completed on the edge that enters SEARCH from ALIGN is not reused; detection resumes on the next edge.

Reset
REQ-024 reset low SHALL immediately force sr = 0, state = SEARCH, bit_cnt = com_cnt = gap_cnt = 0, data_out = 8'h00, valid = 0, active = 0.
REQ-025 Reset SHALL dominate any simultaneous boundary or state transition.
REQ-026 After reset deasserts mid-stream, the block SHALL require a fresh COM detection and LOCK_COUNT COMs before any valid.

Structure
REQ-027 A shared package s2p_pkg SHALL hold the COM, LOCK_COUNT and MAX_GAP defaults and the FSM state encoding.
REQ-028 The 8-bit shift register SHALL be a sub-module s2p_shift (clk, reset, din, q[7:0]); the FSM and counters SHALL stay in s2p_frame_ctrl.
REQ-029 Counter widths SHALL be sized from the parameters; no counter SHALL wrap within its legal range.

Verification
REQ-030 Send 4 x 8'hBC MSB-first, then 8'h5A -> active rises on the 4th COM's 8th-bit edge; 8 cycles later data_out = 8'h5A with a single-cycle valid.
REQ-031 Send 3 x 8'hBC, 8'h00, then 4 x 8'hBC -> no active after the 8'h00 (back to SEARCH); active rises only after the 4 new COMs.
REQ-032 Send 3 junk bits (1,0,1), then 4 x 8'hBC, 8'hC3 -> lock at 3-bit offset; data_out = 8'hC3.
REQ-033 While locked, send 16 x 8'h00 -> 15 valid strobes with data_out = 8'h00; on the 16th byte boundary active = 0 and valid = 0.
REQ-034 While locked, pull reset low mid-byte -> all outputs 0 asynchronously; after release, the bench sees no valid until 4 new COMs.
REQ-035 Drive random din for 2000 cycles with checker -> valid only when active = 1, at most one valid per 8 cycles.

Source files
------------

// File: rtl/s2p_pkg.sv
// Shared defaults and FSM encoding for the serial-to-parallel frame aligner.
package s2p_pkg;

  localparam logic [7:0] COM_DEFAULT        = 8'hBC;
  localparam int         LOCK_COUNT_DEFAULT = 4;
  localparam int         MAX_GAP_DEFAULT    = 16;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/s2p_shift.sv
// 8-bit MSB-first serial shift register feeding the frame aligner.
module s2p_shift (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 8'h00;
    else        q <= {q[6:0], din};
  end

endmodule

// File: rtl/s2p_frame_ctrl.sv
// Byte aligner: finds COM characters in a serial stream, locks after LOCK_COUNT
// aligned COMs and emits one strobed byte per 8 bits until MAX_GAP non-COM bytes.
module s2p_frame_ctrl
  import s2p_pkg::*;
#(
  parameter logic [7:0] COM        = COM_DEFAULT,
  parameter int         LOCK_COUNT = LOCK_COUNT_DEFAULT,
  parameter int         MAX_GAP    = MAX_GAP_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       active
);

  localparam int COM_W = $clog2(LOCK_COUNT + 1);
  localparam int GAP_W = $clog2(MAX_GAP + 1);

  logic [7:0]       w_sr;
  logic [7:0]       w_window;
  logic             w_unused_msb;
  logic             w_is_com;
  logic             w_boundary;
  logic [COM_W-1:0] w_com_inc;
  logic [GAP_W-1:0] w_gap_inc;

  state_t           r_state;
  logic [2:0]       r_bit_cnt;
  logic [COM_W-1:0] r_com_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_active;

  state_t           w_state_nxt;
  logic [2:0]       w_bit_nxt;
  logic [COM_W-1:0] w_com_nxt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [7:0]       w_data_nxt;
  logic             w_valid_nxt;

  s2p_shift u_shift (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .q     (w_sr)
  );

  // The window includes the bit being sampled now, so a byte is seen on its 8th-bit edge.
  assign w_window     = {w_sr[6:0], din};
  assign w_unused_msb = w_sr[7];
  assign w_is_com     = (w_window == COM);
  assign w_boundary   = (r_bit_cnt == 3'd7);
  assign w_com_inc    = r_com_cnt + COM_W'(1);
  assign w_gap_inc    = r_gap_cnt + GAP_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt + 3'd1;
    w_com_nxt   = r_com_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        w_bit_nxt = 3'd0;
        if (w_is_com) begin
          w_state_nxt = ST_ALIGN;
          w_com_nxt   = COM_W'(1);
        end
      end
      ST_ALIGN: begin
        if (w_boundary) begin
          if (w_is_com && (w_com_inc == COM_W'(LOCK_COUNT))) begin
            w_state_nxt = ST_ACTIVE;
            w_com_nxt   = '0;
            w_gap_nxt   = '0;
          end else if (w_is_com) begin
            w_com_nxt = w_com_inc;
          end else begin
            w_state_nxt = ST_SEARCH;
            w_com_nxt   = '0;
          end
        end
      end
      ST_ACTIVE: begin
        // The byte that exhausts the gap budget is dropped, not delivered.
        if (w_boundary) begin
          if (w_is_com) begin
            w_gap_nxt   = '0;
            w_data_nxt  = w_window;
            w_valid_nxt = 1'b1;
          end else if (w_gap_inc == GAP_W'(MAX_GAP)) begin
            w_state_nxt = ST_SEARCH;
            w_gap_nxt   = '0;
          end else begin
            w_gap_nxt   = w_gap_inc;
            w_data_nxt  = w_window;
            w_valid_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
        w_com_nxt   = '0;
        w_gap_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_SEARCH;
      r_bit_cnt <= 3'd0;
      r_com_cnt <= '0;
      r_gap_cnt <= '0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_com_cnt <= w_com_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_active  <= (w_state_nxt == ST_ACTIVE);
    end
  end

  assign data_out = r_data;
  assign valid    = r_valid;
  assign active   = r_active;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Directed bench for s2p_frame_ctrl: lock, loss of lock, offset lock, async reset, random stream.
module tb_s2p_frame_ctrl;

  logic       clk;
  logic       reset;
  logic       din;
  logic [7:0] data_out;
  logic       valid;
  logic       active;

  int numVectors = 0;
  int numFails   = 0;

  s2p_frame_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .data_out (data_out),
    .valid    (valid),
    .active   (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    numVectors++;
    assert (observed === expected) else begin
      numFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive on the falling edge, observe 1 time unit after the rising edge.
  task automatic applyStimulus(input logic b);
    @(negedge clk);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input string tag, input logic [7:0] b, input logic expValid,
                          input logic [7:0] expData, input logic expActive);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(b[i]);
      if (i > 0) begin
        checkOutput({tag, ".validMid"}, {7'd0, valid}, 8'd0);
      end else begin
        checkOutput({tag, ".valid"}, {7'd0, valid}, {7'd0, expValid});
        checkOutput({tag, ".active"}, {7'd0, active}, {7'd0, expActive});
        if (expValid) checkOutput({tag, ".data"}, data_out, expData);
      end
    end
  endtask

  initial begin
    int lastValid;
    reset = 1'b0;
    din   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.data", data_out, 8'h00);
    checkOutput("rst.valid", {7'd0, valid}, 8'd0);
    checkOutput("rst.active", {7'd0, active}, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic lock then first payload byte
    sendByte("lockA.com1", 8'hBC, 1'b0, 8'h00, 1'b0);
    sendByte("lockA.com2", 8'hBC, 1'b0, 8'h00, 1'b0);
    sendByte("lockA.com3", 8'hBC, 1'b0, 8'h00, 1'b0);
    sendByte("lockA.com4", 8'hBC, 1'b0, 8'h00, 1'b1);
    sendByte("lockA.data", 8'h5A, 1'b1, 8'h5A, 1'b1);
    sendByte("lockA.comOut", 8'hBC, 1'b1, 8'hBC, 1'b1);

    // Fifteen gap bytes are delivered, the sixteenth drops lock
    for (int k = 0; k < 15; k++) sendByte("gap.byte", 8'h00, 1'b1, 8'h00, 1'b1);
    sendByte("gap.last", 8'h00, 1'b0, 8'h00, 1'b0);

    // Broken COM run falls back to search before relocking
    sendByte("relock.com1", 8'hBC, 1'b0, 8'h00, 1'b0);
    sendByte("relock.com2", 8'hBC, 1'b0, 8'h00, 1'b0);
    sendByte("relock.com3", 8'hBC, 1'b0, 8'h00, 1'b0);
    sendByte("relock.break", 8'h00, 1'b0, 8'h00, 1'b0);
    sendByte("relock.new1", 8'hBC, 1'b0, 8'h00, 1'b0);
    sendByte("relock.new2", 8'hBC, 1'b0, 8'h00, 1'b0);
    sendByte("relock.new3", 8'hBC, 1'b0, 8'h00, 1'b0);
    sendByte("relock.new4", 8'hBC, 1'b0, 8'h00, 1'b1);
    sendByte("relock.data", 8'hA5, 1'b1, 8'hA5, 1'b1);

    // Asynchronous reset in the middle of a byte
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async.data", data_out, 8'h00);
    checkOutput("async.valid", {7'd0, valid}, 8'd0);
    checkOutput("async.active", {7'd0, active}, 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Three junk bits put the byte grid at a 3-bit offset
    applyStimulus(1'b1);
    checkOutput("offset.junk1", {7'd0, valid}, 8'd0);
    applyStimulus(1'b0);
    checkOutput("offset.junk2", {7'd0, valid}, 8'd0);
    applyStimulus(1'b1);
    checkOutput("offset.junk3", {7'd0, valid}, 8'd0);
    sendByte("offset.com1", 8'hBC, 1'b0, 8'h00, 1'b0);
    sendByte("offset.com2", 8'hBC, 1'b0, 8'h00, 1'b0);
    sendByte("offset.com3", 8'hBC, 1'b0, 8'h00, 1'b0);
    sendByte("offset.com4", 8'hBC, 1'b0, 8'h00, 1'b1);
    sendByte("offset.data", 8'hC3, 1'b1, 8'hC3, 1'b1);

    // Random stream: valid only while active, strobes at least 8 cycles apart
    lastValid = -100;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      applyStimulus(1'($urandom_range(0, 1)));
      if (valid) begin
        checkOutput("rand.validActive", {7'd0, active}, 8'd1);
        checkOutput("rand.spacing", {7'd0, (cyc - lastValid) >= 8}, 8'd1);
        lastValid = cyc;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numFails);
    $finish;
  end

endmodule
